ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// frame length and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Start, 8 data bits and parity are driven; the 10th edge releases for stop.
    localparam int unsigned BIT_COUNT = 10;
    localparam logic [3:0]  LAST_BIT  = 4'(BIT_COUNT - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one raw PS/2 line with falling-edge detect.
// All flops reset to the idle-high level of the bus.
module ps2_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta   <= 1'b1;
            line_s <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= line_in;
            line_s <= meta;
            prev   <= line_s;
        end
    end

    assign fall = prev & ~line_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain style line enables.
// Optional ACK watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | lines released, ready for a byte
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | data pulled low with clock still low (request-to-send)
// SHIFT     | clock released, bits updated on each device falling edge
// ACK       | data released, sample device ACK on next falling edge
// WAIT_IDLE | wait for both lines high before accepting again
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    ps2_state_e state_q, state_d;

    logic                 clk_s, clk_fall;
    logic                 data_s, data_fall_unused;
    logic [7:0]           data_q;
    logic                 parity_q;
    logic [INH_W-1:0]     inh_cnt;
    logic [3:0]           bit_cnt;
    logic                 ack_ok;
    logic                 timeout;
    logic [BIT_COUNT-1:0] frame;

    ps2_sync u_sync_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (ps2_clk_in),
        .line_s  (clk_s),
        .fall    (clk_fall)
    );

    ps2_sync u_sync_data (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (ps2_data_in),
        .line_s  (data_s),
        .fall    (data_fall_unused)
    );

    assign frame = {parity_q, data_q, 1'b0};

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Armed as the clock is released; expires after TIMEOUT_CYCLES in SHIFT/ACK.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state_q == RTS) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == SHIFT || state_q == ACK) && wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign timeout = (state_q == SHIFT || state_q == ACK) && (wd_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tx_valid) state_d = INHIBIT;
            INHIBIT:   if (inh_cnt == '0) state_d = RTS;
            RTS:       state_d = SHIFT;
            SHIFT:     if (clk_fall && bit_cnt == LAST_BIT) state_d = ACK;
            ACK:       if (clk_fall) state_d = WAIT_IDLE;
            WAIT_IDLE: if (clk_s && data_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
            end
            INHIBIT: ps2_clk_oe = 1'b1;
            RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            SHIFT:   ps2_data_oe = ~frame[bit_cnt];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= '0;
            parity_q <= 1'b0;
            inh_cnt  <= '0;
            bit_cnt  <= '0;
            ack_ok   <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        data_q   <= tx_data;
                        parity_q <= odd_parity(tx_data);
                        inh_cnt  <= INH_W'(INHIBIT_CYCLES - 1);
                    end
                end
                INHIBIT: begin
                    if (inh_cnt != '0) inh_cnt <= inh_cnt - 1'b1;
                end
                RTS: begin
                    bit_cnt <= '0;
                    ack_ok  <= 1'b0;
                end
                SHIFT: begin
                    if (clk_fall) bit_cnt <= bit_cnt + 4'd1;
                end
                ACK: begin
                    if (clk_fall) begin
                        ack_ok <= ~data_s;
                        tx_err <= data_s;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) tx_done <= ack_ok;
                end
                default: ;
            endcase
            // Timeout wins over a coincident ACK sample so only tx_err pulses.
            if (timeout) begin
                tx_err <= 1'b1;
                ack_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 1000;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int HALF_SLOW = 40;
    localparam int HALF_FAST = 40;
`else
    localparam int HALF_SLOW = 2000;   // 80 us bit period at 50 MHz
    localparam int HALF_FAST = 200;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    int total = 0;
    int bad = 0;
    int inh_cnt = 0, rts_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe)  rts_cnt++;
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Clock released with start bit on the line marks the SHIFT entry.
    task automatic wait_release(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2_data_oe && !ps2_clk_oe) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Device: bits[0]=start, [1..8]=data, [9]=parity, [10]=stop, sampled while clock low.
    task automatic dev_frame(input bit ack, input int half, input int nedges,
                             output logic [10:0] bits, output logic busy11);
        bit ok;
        bits   = '1;
        busy11 = 1'b0;
        wait_release(ok);
        check("clk_release", 32'(ok), 32'd1);
        if (!ok) return;
        repeat (half) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int k = 1; k <= nedges && k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            bits[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        if (nedges > 10) begin
            dev_data_low = ack;
            repeat (half / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            busy11 = busy;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] bits;
        logic        b11;
        bit          ok;
        int          i0, r0, d0, e0, cnt;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 0xED with ACK
        i0 = inh_cnt; r0 = rts_cnt; d0 = done_cnt; e0 = err_cnt;
        tx_data = 8'hED; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_low", 32'(tx_ready), 32'd0);
        dev_frame(1'b1, HALF_SLOW, 11, bits, b11);
        check("t1_start", 32'(bits[0]), 32'd0);
        check("t1_bit0", 32'(bits[1]), 32'd1);
        check("t1_bit1", 32'(bits[2]), 32'd0);
        check("t1_bit2", 32'(bits[3]), 32'd1);
        check("t1_bit3", 32'(bits[4]), 32'd1);
        check("t1_bit4", 32'(bits[5]), 32'd0);
        check("t1_bit5", 32'(bits[6]), 32'd1);
        check("t1_bit6", 32'(bits[7]), 32'd1);
        check("t1_bit7", 32'(bits[8]), 32'd1);
        check("t1_parity", 32'(bits[9]), 32'd1);
        check("t1_stop", 32'(bits[10]), 32'd1);
        wait_ready(ok);
        check("t1_idle", 32'(ok), 32'd1);
        @(negedge clk);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("t1_inhibit_clocks", 32'(inh_cnt - i0), 32'(INH));
        check("t1_rts_clocks", 32'(rts_cnt - r0), 32'd1);

        // 0x00 with NACK
        d0 = done_cnt; e0 = err_cnt;
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b0, HALF_FAST, 11, bits, b11);
        check("t2_data", 32'(bits[8:1]), 32'h00);
        check("t2_parity", 32'(bits[9]), 32'd1);
        check("t2_busy_at_edge11", 32'(b11), 32'd1);
        wait_ready(ok);
        check("t2_idle", 32'(ok), 32'd1);
        @(negedge clk);
        check("t2_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd0);

        // tx_valid held: 0xAA sent, 0x55 only on the following tx_ready
        d0 = done_cnt;
        tx_data = 8'hAA; tx_valid = 1'b1;
        @(negedge clk);
        check("t3_busy", 32'(busy), 32'd1);
        tx_data = 8'h55;
        dev_frame(1'b1, HALF_FAST, 11, bits, b11);
        check("t3_first_byte", 32'(bits[8:1]), 32'hAA);
        check("t3_first_parity", 32'(bits[9]), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (tx_done) ok = 1'b1;
        end
        check("t3_first_done", 32'(ok), 32'd1);
        @(negedge clk);
        check("t3_second_accept", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        dev_frame(1'b1, HALF_FAST, 11, bits, b11);
        check("t3_second_byte", 32'(bits[8:1]), 32'h55);
        check("t3_second_parity", 32'(bits[9]), 32'd1);
        wait_ready(ok);
        check("t3_idle", 32'(ok), 32'd1);
        @(negedge clk);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd2);

        // device that never clocks
        e0 = err_cnt;
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_release(ok);
        check("t4_release", 32'(ok), 32'd1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            @(negedge clk);
            cnt++;
            if (tx_err) break;
        end
        check("t4_timeout_clocks", 32'(cnt), 32'(TMO));
        check("t4_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t4_data_oe", 32'(ps2_data_oe), 32'd0);
        check("t4_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        check("t4_err_pulses", 32'(err_cnt - e0), 32'd1);
`else
        cnt = 0;
        repeat (TMO + 100) @(negedge clk);
        check("t4_still_busy", 32'(busy), 32'd1);
        check("t4_no_err", 32'(err_cnt - e0), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t4_recovered", 32'(tx_ready), 32'd1);
`endif

        // reset in the middle of the frame, after data bit 4 is on the line
        d0 = done_cnt; e0 = err_cnt;
        tx_data = 8'h0F; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b1, HALF_FAST, 5, bits, b11);
        check("t5_low_nibble", 32'(bits[4:1]), 32'hF);
        check("t5_bit4", 32'(bits[5]), 32'd0);
        check("t5_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t5_data_oe", 32'(ps2_data_oe), 32'd0);
        check("t5_ready", 32'(tx_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd0);
        check("t5_idle", 32'(tx_ready), 32'd1);
        check("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
